// File: rtl/xbar_req_scheduler.sv
// Upstream scheduler for the M-to-N crossbar: per-requester FIFOs, per-destination
// round-robin pick of FIFO heads, registered conflict-free lane outputs.
module xbar_req_scheduler #(
    parameter int M          = 8,
    parameter int N          = 16,
    parameter int PLD_WIDTH  = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [M-1:0]                  req_vld,
    output logic [M-1:0]                  req_rdy,
    input  logic [M-1:0][PLD_WIDTH-1:0]   req_pld,
    input  logic [M-1:0][$clog2(N)-1:0]   req_dst,
    input  logic [N-1:0]                  dst_rdy,
    output logic [M-1:0]                  xbar_vld,
    output logic [M-1:0][PLD_WIDTH-1:0]   xbar_pld,
    output logic [M-1:0][$clog2(N)-1:0]   xbar_sel
);
    localparam int DW = $clog2(N);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int RW = $clog2(M);

    logic [PLD_WIDTH-1:0]        mem_pld [M][FIFO_DEPTH];
    logic [DW-1:0]               mem_dst [M][FIFO_DEPTH];
    logic [M-1:0][PW-1:0]        wr_ptr;
    logic [M-1:0][PW-1:0]        rd_ptr;
    logic [M-1:0][CW-1:0]        count;
    logic [N-1:0][RW-1:0]        rr;
    logic [N-1:0][RW-1:0]        rr_next;
    logic [M-1:0][PLD_WIDTH-1:0] head_pld;
    logic [M-1:0][DW-1:0]        head_dst;
    logic [M-1:0][N-1:0]         cand;
    logic [M-1:0]                push;
    logic [M-1:0]                grant;

    // Ready is forced low during reset; a full FIFO never accepts, even while popping.
    always_comb begin
        for (int i = 0; i < M; i++) begin
            req_rdy[i]  = (count[i] != CW'(FIFO_DEPTH)) & ~rst;
            head_pld[i] = mem_pld[i][rd_ptr[i]];
            head_dst[i] = mem_dst[i][rd_ptr[i]];
        end
    end

    assign push = req_vld & req_rdy;

    always_comb begin
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < N; j++) begin
                cand[i][j] = (count[i] != '0) && (int'(head_dst[i]) == j) && dst_rdy[j];
            end
        end
    end

    // Each destination independently grants the first candidate at or after its pointer.
    always_comb begin
        logic found;
        int   idx;
        grant   = '0;
        rr_next = rr;
        found   = 1'b0;
        idx     = 0;
        for (int j = 0; j < N; j++) begin
            found = 1'b0;
            for (int k = 0; k < M; k++) begin
                idx = (int'(rr[j]) + k) % M;
                if (!found && cand[idx][j]) begin
                    found      = 1'b1;
                    grant[idx] = 1'b1;
                    rr_next[j] = RW'((idx + 1) % M);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < M; i++) begin
            if (push[i]) begin
                mem_pld[i][wr_ptr[i]] <= req_pld[i];
                mem_dst[i][wr_ptr[i]] <= req_dst[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rr     <= '0;
        end else begin
            rr <= rr_next;
            for (int i = 0; i < M; i++) begin
                if (push[i])
                    wr_ptr[i] <= wr_ptr[i] + PW'(1);
                if (grant[i])
                    rd_ptr[i] <= rd_ptr[i] + PW'(1);
                case ({push[i], grant[i]})
                    2'b10:   count[i] <= count[i] + CW'(1);
                    2'b01:   count[i] <= count[i] - CW'(1);
                    default: count[i] <= count[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xbar_vld <= '0;
            xbar_pld <= '0;
            xbar_sel <= '0;
        end else begin
            xbar_vld <= grant;
            for (int i = 0; i < M; i++) begin
                xbar_pld[i] <= grant[i] ? head_pld[i] : '0;
                xbar_sel[i] <= grant[i] ? head_dst[i] : '0;
            end
        end
    end
endmodule

// File: tb/tb_xbar_req_scheduler.sv
// Directed bench for xbar_req_scheduler: table of per-cycle vectors plus
// hand-written reset, parallel-lane and mid-drain reset sequences.
module tb_xbar_req_scheduler;
    localparam int M  = 8;
    localparam int N  = 16;
    localparam int PW = 32;
    localparam int NV = 27;

    logic                 clk;
    logic                 rst;
    logic [M-1:0]         req_vld;
    logic [M-1:0]         req_rdy;
    logic [M-1:0][PW-1:0] req_pld;
    logic [M-1:0][3:0]    req_dst;
    logic [N-1:0]         dst_rdy;
    logic [M-1:0]         xbar_vld;
    logic [M-1:0][PW-1:0] xbar_pld;
    logic [M-1:0][3:0]    xbar_sel;

    int checks;
    int errors;

    typedef struct {
        logic [7:0]  vld;
        logic [31:0] pld;
        logic [3:0]  dst;
        logic [15:0] drdy;
        logic [7:0]  exp_rdy;
        logic [7:0]  exp_vld;
        logic [3:0]  exp_sel;
        logic [31:0] exp_pld;
    } vec_t;

    vec_t vecs [NV];

    xbar_req_scheduler #(
        .M(M), .N(N), .PLD_WIDTH(PW), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_pld(req_pld), .req_dst(req_dst),
        .dst_rdy(dst_rdy),
        .xbar_vld(xbar_vld), .xbar_pld(xbar_pld), .xbar_sel(xbar_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Requester i gets payload pld+i; all pushing requesters share one destination.
    task automatic applyStimulus(input logic [7:0] vld, input logic [31:0] pld,
                                 input logic [3:0] dst, input logic [15:0] drdy);
        req_vld = vld;
        dst_rdy = drdy;
        for (int i = 0; i < M; i++) begin
            req_pld[i] = pld + 32'(i);
            req_dst[i] = dst;
        end
    endtask

    task automatic tick;
        logic conflict;
        @(posedge clk);
        #1;
        conflict = 1'b0;
        for (int i = 0; i < M; i++)
            for (int k = i + 1; k < M; k++)
                if (xbar_vld[i] && xbar_vld[k] && xbar_sel[i] == xbar_sel[k])
                    conflict = 1'b1;
        checkOutput("lane_sel_conflict", {31'b0, conflict}, 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;

        vecs[0]  = '{8'h08, 32'hA2, 4'd5, 16'hFFFF, 8'hFF, 8'h00, 4'd0, 32'h0};
        vecs[1]  = '{8'h00, 32'h00, 4'd0, 16'hFFFF, 8'hFF, 8'h08, 4'd5, 32'hA5};
        vecs[2]  = '{8'h00, 32'h00, 4'd0, 16'hFFFF, 8'hFF, 8'h00, 4'd0, 32'h0};
        vecs[3]  = '{8'h03, 32'h10, 4'd7, 16'hFF7F, 8'hFF, 8'h00, 4'd0, 32'h0};
        vecs[4]  = '{8'h03, 32'h20, 4'd7, 16'hFF7F, 8'hFF, 8'h00, 4'd0, 32'h0};
        vecs[5]  = '{8'h00, 32'h00, 4'd0, 16'hFFFF, 8'hFF, 8'h01, 4'd7, 32'h10};
        vecs[6]  = '{8'h00, 32'h00, 4'd0, 16'hFFFF, 8'hFF, 8'h02, 4'd7, 32'h11};
        vecs[7]  = '{8'h00, 32'h00, 4'd0, 16'hFFFF, 8'hFF, 8'h01, 4'd7, 32'h20};
        vecs[8]  = '{8'h00, 32'h00, 4'd0, 16'hFFFF, 8'hFF, 8'h02, 4'd7, 32'h21};
        vecs[9]  = '{8'h00, 32'h00, 4'd0, 16'hFFFF, 8'hFF, 8'h00, 4'd0, 32'h0};
        vecs[10] = '{8'h01, 32'h40, 4'd4, 16'hFFEF, 8'hFF, 8'h00, 4'd0, 32'h0};
        vecs[11] = '{8'h01, 32'h41, 4'd4, 16'hFFEF, 8'hFF, 8'h00, 4'd0, 32'h0};
        vecs[12] = '{8'h01, 32'h42, 4'd4, 16'hFFEF, 8'hFF, 8'h00, 4'd0, 32'h0};
        vecs[13] = '{8'h01, 32'h43, 4'd4, 16'hFFEF, 8'hFE, 8'h00, 4'd0, 32'h0};
        vecs[14] = '{8'h01, 32'h99, 4'd4, 16'hFFEF, 8'hFE, 8'h00, 4'd0, 32'h0};
        vecs[15] = '{8'h00, 32'h00, 4'd0, 16'hFFFF, 8'hFF, 8'h01, 4'd4, 32'h40};
        vecs[16] = '{8'h00, 32'h00, 4'd0, 16'hFFFF, 8'hFF, 8'h01, 4'd4, 32'h41};
        vecs[17] = '{8'h00, 32'h00, 4'd0, 16'hFFFF, 8'hFF, 8'h01, 4'd4, 32'h42};
        vecs[18] = '{8'h00, 32'h00, 4'd0, 16'hFFFF, 8'hFF, 8'h01, 4'd4, 32'h43};
        vecs[19] = '{8'h00, 32'h00, 4'd0, 16'hFFFF, 8'hFF, 8'h00, 4'd0, 32'h0};
        vecs[20] = '{8'h01, 32'h50, 4'd2, 16'hFFFB, 8'hFF, 8'h00, 4'd0, 32'h0};
        vecs[21] = '{8'h03, 32'h60, 4'd3, 16'hFFFB, 8'hFF, 8'h00, 4'd0, 32'h0};
        vecs[22] = '{8'h00, 32'h00, 4'd0, 16'hFFFB, 8'hFF, 8'h02, 4'd3, 32'h61};
        vecs[23] = '{8'h00, 32'h00, 4'd0, 16'hFFFB, 8'hFF, 8'h00, 4'd0, 32'h0};
        vecs[24] = '{8'h00, 32'h00, 4'd0, 16'hFFFF, 8'hFF, 8'h01, 4'd2, 32'h50};
        vecs[25] = '{8'h00, 32'h00, 4'd0, 16'hFFFF, 8'hFF, 8'h01, 4'd3, 32'h60};
        vecs[26] = '{8'h00, 32'h00, 4'd0, 16'hFFFF, 8'hFF, 8'h00, 4'd0, 32'h0};

        rst = 1'b1;
        applyStimulus(8'hFF, 32'h0, 4'd0, 16'hFFFF);
        tick;
        tick;
        checkOutput("reset_req_rdy", 32'(req_rdy), 32'h00);
        checkOutput("reset_xbar_vld", 32'(xbar_vld), 32'h00);
        checkOutput("reset_xbar_pld0", xbar_pld[0], 32'h0);
        req_vld = 8'h00;
        rst = 1'b0;
        #1;
        checkOutput("release_req_rdy", 32'(req_rdy), 32'hFF);
        tick;
        checkOutput("idle_xbar_vld_a", 32'(xbar_vld), 32'h00);
        tick;
        checkOutput("idle_xbar_vld_b", 32'(xbar_vld), 32'h00);

        for (int v = 0; v < NV; v++) begin
            applyStimulus(vecs[v].vld, vecs[v].pld, vecs[v].dst, vecs[v].drdy);
            tick;
            checkOutput($sformatf("vec%0d_req_rdy", v), 32'(req_rdy), 32'(vecs[v].exp_rdy));
            checkOutput($sformatf("vec%0d_xbar_vld", v), 32'(xbar_vld), 32'(vecs[v].exp_vld));
            for (int i = 0; i < M; i++) begin
                if (vecs[v].exp_vld[i]) begin
                    checkOutput($sformatf("vec%0d_sel%0d", v, i), 32'(xbar_sel[i]), 32'(vecs[v].exp_sel));
                    checkOutput($sformatf("vec%0d_pld%0d", v, i), xbar_pld[i], vecs[v].exp_pld);
                end
            end
        end

        // All requesters to distinct destinations: every lane fires together.
        applyStimulus(8'hFF, 32'h100, 4'd0, 16'hFFFF);
        for (int i = 0; i < M; i++)
            req_dst[i] = 4'(i + 8);
        tick;
        checkOutput("par_push_vld", 32'(xbar_vld), 32'h00);
        applyStimulus(8'h00, 32'h0, 4'd0, 16'hFFFF);
        tick;
        checkOutput("par_xbar_vld", 32'(xbar_vld), 32'hFF);
        for (int i = 0; i < M; i++) begin
            checkOutput($sformatf("par_sel%0d", i), 32'(xbar_sel[i]), 32'(i + 8));
            checkOutput($sformatf("par_pld%0d", i), xbar_pld[i], 32'h100 + 32'(i));
        end
        tick;
        checkOutput("par_drain_vld", 32'(xbar_vld), 32'h00);

        // Reset while a beat is registered and two entries remain queued.
        applyStimulus(8'h01, 32'h70, 4'd6, 16'hFFBF);
        tick;
        applyStimulus(8'h01, 32'h71, 4'd6, 16'hFFBF);
        tick;
        applyStimulus(8'h01, 32'h72, 4'd6, 16'hFFBF);
        tick;
        applyStimulus(8'h00, 32'h0, 4'd0, 16'hFFFF);
        tick;
        checkOutput("drain_xbar_vld", 32'(xbar_vld), 32'h01);
        checkOutput("drain_xbar_pld0", xbar_pld[0], 32'h70);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_xbar_vld", 32'(xbar_vld), 32'h00);
        checkOutput("midrst_xbar_pld0", xbar_pld[0], 32'h0);
        checkOutput("midrst_req_rdy", 32'(req_rdy), 32'h00);
        tick;
        rst = 1'b0;
        #1;
        checkOutput("midrst_release_rdy", 32'(req_rdy), 32'hFF);
        tick;
        checkOutput("midrst_stale_a", 32'(xbar_vld), 32'h00);
        tick;
        checkOutput("midrst_stale_b", 32'(xbar_vld), 32'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/xbar_req_scheduler.md
# xbar_req_scheduler

Upstream scheduler for the M-to-N vector-cache crossbar. It buffers per-requester payloads in small FIFOs and picks, each cycle, a conflict-free set of FIFO heads: at most one per destination, only to ready destinations. Picks go out registered on the crossbar's valid/payload/select inputs. Its key guarantee is that no two valid crossbar lanes ever share a select value, so the crossbar's conflict assertion can never fire.

## Interface
- M, 8, number of requesters / crossbar inputs
- N, 16, number of destinations / crossbar outputs
- PLD_WIDTH, 32, payload width
- FIFO_DEPTH, 4, entries per requester FIFO (power of 2, ≥2)

- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_vld  in  [M-1:0]  requester i presents an entry
- req_rdy  out  [M-1:0]  FIFO i can accept; handshake = req_vld[i] & req_rdy[i] at a rising edge
- req_pld  in  [PLD_WIDTH-1:0] x M  entry payload
- req_dst  in  [$clog2(N)-1:0] x M  entry destination index
- dst_rdy  in  [N-1:0]  destination j guarantees acceptance of a beat presented on the cycle after this sample
- xbar_vld  out  [M-1:0]  registered lane valid to crossbar
- xbar_pld  out  [PLD_WIDTH-1:0] x M  registered lane payload
- xbar_sel  out  [$clog2(N)-1:0] x M  registered lane destination select

## Operation
- Per requester i: FIFO of FIFO_DEPTH entries {pld, dst}, with wr_ptr, rd_ptr (wrap modulo FIFO_DEPTH) and count (width $clog2(FIFO_DEPTH+1)).
- req_rdy[i] = (count[i] != FIFO_DEPTH) & ~rst. No full-bypass: a full FIFO popping this cycle still shows req_rdy=0.
- Push and pop in the same cycle on a non-full FIFO: count unchanged, both pointers advance.
- An entry pushed at edge t is a head candidate from cycle t+1. There is no empty-FIFO bypass.
- Candidate cand[i][j] = (count[i]!=0) & (head_dst[i]==j) & dst_rdy[j].
- Per destination j, round-robin pointer rr[j] (width $clog2(M), reset 0):
  - grant goes to the first i with cand[i][j], scanning i = rr[j], rr[j]+1, … modulo M;
  - on a grant, rr[j] <= granted i + 1 (mod M); with no grant, rr[j] holds.
- Each input has one head, so each input gets at most one grant per cycle. grant[i] = OR over j of the per-destination grants.
- grant[i] pops FIFO i at the same edge.
- Output register, loaded every edge:
  - xbar_vld[i] <= grant[i];
  - xbar_pld[i] <= grant ? head_pld[i] : 0;
  - xbar_sel[i] <= grant ? head_dst[i] : 0.
- Head-of-line blocking is intended. A blocked head stalls all later entries of that FIFO, regardless of their destination.
- Invariant: for all i≠k, xbar_vld[i] & xbar_vld[k] implies xbar_sel[i] != xbar_sel[k].
- Invariant: every xbar_vld beat to destination j was granted while dst_rdy[j]=1 one cycle earlier.

## Timing
- Reset (async assert, sync release): all FIFOs empty, pointers and counts 0, rr all 0, xbar_vld=0, xbar_pld=0, xbar_sel=0. req_rdy=0 while rst is high and all-ones on the first cycle after release.
- Reset mid-operation discards all buffered entries and any in-flight output beat. Outputs go to their reset values immediately on assertion.
- Latency: handshake at edge t → grant in cycle t+1 → xbar_vld high in cycle t+2 (minimum 2 cycles).
- Throughput: one beat per requester per cycle, and one beat per destination per cycle.
- dst_rdy is sampled combinationally in the grant cycle and is not registered. A destination dropping dst_rdy stops new grants the same cycle; a beat already registered is still delivered.
- Full/empty boundaries: count == FIFO_DEPTH gives req_rdy=0; count == 0 gives no candidate. Pointer wrap from FIFO_DEPTH-1 to 0 must not corrupt data.

## Test plan
- Reset: hold rst with req_vld=all ones → req_rdy=0, xbar_vld=0. Release → req_rdy=0xFF next cycle, no xbar_vld until entries exist.
- Single beat: input 3 pushes pld=0xA5, dst=5, dst_rdy=all ones, handshake at edge t → xbar_vld=0x08, xbar_sel[3]=5, xbar_pld[3]=0xA5 in cycle t+2 only.
- Fairness: inputs 0 and 1 each hold 2 entries to dst 7, rr[7]=0, dst_rdy[7]=1 → xbar_vld sequence 0x01,0x02,0x01,0x02 on consecutive cycles, xbar_sel=7 each time, never two lanes at once.
- Backpressure/full: dst_rdy[4]=0, input 0 pushes 4 entries to dst 4 → req_rdy[0]=0 after the 4th handshake, no xbar_vld. Raise dst_rdy[4] → one beat per cycle, payloads in push order, req_rdy[0]=1 the cycle after the first pop.
- Head-of-line and parallel: input 0 head to dst 2 (dst_rdy[2]=0) with its 2nd entry to dst 3; input 1 pushes to dst 3 → input 1 delivered, input 0 stalled until dst_rdy[2]=1, then dst 2 beat followed by dst 3 beat.
- Reset mid-drain: 3 entries queued, assert rst asynchronously between edges → xbar_vld=0 immediately. After release, no stale beat appears and req_rdy is all ones.
